// File: rtl/spi_ram_master.sv
// spi_ram_master: SPI mode-0 initiator for the byte-stream RAM protocol.
// Sends cmd, address, dummy bytes and data; SCK is divided from clk.
module spi_ram_master #(
  parameter int c_clk_div    = 4,
  parameter int c_addr_bits  = 32,
  parameter int c_read_dummy = 1,
  parameter int c_len_bits   = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   rw,
  input  logic [c_addr_bits-1:0] addr,
  input  logic [c_len_bits-1:0]  len,
  input  logic [7:0]             wr_data,
  output logic                   wr_ready,
  output logic [7:0]             rd_data,
  output logic                   rd_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   spi_csn,
  output logic                   spi_sck,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);
  localparam int TW = (c_clk_div > 1) ? $clog2(c_clk_div) : 1;
  localparam logic [TW-1:0] TMAX = TW'(c_clk_div - 1);
  localparam logic [2:0] ALAST = 3'(c_addr_bits / 8 - 1);
  localparam logic [7:0] DLAST = 8'(c_read_dummy - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [1:0] P_CMD   = 2'd0;
  localparam logic [1:0] P_ADDR  = 2'd1;
  localparam logic [1:0] P_DUMMY = 2'd2;
  localparam logic [1:0] P_DATA  = 2'd3;

  logic [2:0]             state_q, state_d;
  logic [TW-1:0]          tick_q, tick_d;
  logic                   sck_q, sck_d;
  logic [2:0]             bit_q, bit_d;
  logic [1:0]             ph_q, ph_d;
  logic [2:0]             abyte_q, abyte_d;
  logic [7:0]             dbyte_q, dbyte_d;
  logic [c_len_bits-1:0]  len_q, len_d;
  logic                   rw_q, rw_d;
  logic [c_addr_bits-1:0] addr_q, addr_d;
  logic [7:0]             sh_q, sh_d;
  logic [6:0]             rx_q, rx_d;
  logic [7:0]             rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;
  logic                   csn_q, csn_d;
  logic                   miso_q1, miso_q2;
  logic                   tick_end, load_data;

  assign tick_end = (tick_q == TMAX);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    sck_d      = sck_q;
    bit_d      = bit_q;
    ph_d       = ph_q;
    abyte_d    = abyte_q;
    dbyte_d    = dbyte_q;
    len_d      = len_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    sh_d       = sh_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;
    csn_d      = csn_q;
    load_data  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          tick_d  = '0;
          sck_d   = 1'b0;
          csn_d   = 1'b0;
          busy_d  = 1'b1;
          rw_d    = rw;
          addr_d  = addr;
          len_d   = len;
        end
      end
      S_SETUP: begin
        tick_d = tick_q + 1'b1;
        if (tick_end) begin
          state_d = S_SHIFT;
          tick_d  = '0;
          ph_d    = P_CMD;
          bit_d   = '0;
          sh_d    = {7'd0, rw_q};
        end
      end
      S_SHIFT: begin
        tick_d = tick_q + 1'b1;
        if (tick_end) begin
          tick_d = '0;
          sck_d  = ~sck_q;
          if (!sck_q) begin
            rx_d = {rx_q[5:0], miso_q2};
            if (bit_q == 3'd7 && ph_q == P_DATA && rw_q) begin
              rd_data_d  = {rx_q, miso_q2};
              rd_valid_d = 1'b1;
            end
          end else if (bit_q != 3'd7) begin
            bit_d = bit_q + 1'b1;
            sh_d  = {sh_q[6:0], 1'b0};
          end else begin
            // Byte boundary: pick the next byte of the frame or finish.
            bit_d = '0;
            sh_d  = '0;
            unique case (ph_q)
              P_CMD: begin
                ph_d    = P_ADDR;
                abyte_d = ALAST;
                sh_d    = addr_q[c_addr_bits-1 -: 8];
                addr_d  = addr_q << 8;
              end
              P_ADDR: begin
                if (abyte_q != 3'd0) begin
                  abyte_d = abyte_q - 1'b1;
                  sh_d    = addr_q[c_addr_bits-1 -: 8];
                  addr_d  = addr_q << 8;
                end else if (rw_q && c_read_dummy > 0) begin
                  ph_d    = P_DUMMY;
                  dbyte_d = DLAST;
                end else if (len_q != '0) begin
                  load_data = 1'b1;
                end else begin
                  state_d = S_HOLD;
                end
              end
              P_DUMMY: begin
                if (dbyte_q != 8'd0) begin
                  dbyte_d = dbyte_q - 1'b1;
                end else if (len_q != '0) begin
                  load_data = 1'b1;
                end else begin
                  state_d = S_HOLD;
                end
              end
              default: begin
                if (len_q != '0) begin
                  load_data = 1'b1;
                end else begin
                  state_d = S_HOLD;
                end
              end
            endcase
            if (load_data) begin
              ph_d  = P_DATA;
              len_d = len_q - 1'b1;
              sh_d  = rw_q ? 8'h00 : wr_data;
            end
          end
        end
      end
      S_HOLD: begin
        tick_d = tick_q + 1'b1;
        if (tick_end) begin
          tick_d = '0;
          csn_d  = 1'b1;
          // The done cycle is the last CSN-high cycle of the gap.
          if (c_clk_div == 1) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_GAP;
            tick_d  = TW'(1);
          end
        end
      end
      S_GAP: begin
        tick_d = tick_q + 1'b1;
        if (tick_end) begin
          tick_d  = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      sck_q      <= 1'b0;
      bit_q      <= '0;
      ph_q       <= P_CMD;
      abyte_q    <= '0;
      dbyte_q    <= '0;
      len_q      <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      sh_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      csn_q      <= 1'b1;
      miso_q1    <= 1'b0;
      miso_q2    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      sck_q      <= sck_d;
      bit_q      <= bit_d;
      ph_q       <= ph_d;
      abyte_q    <= abyte_d;
      dbyte_q    <= dbyte_d;
      len_q      <= len_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      sh_q       <= sh_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      csn_q      <= csn_d;
      miso_q1    <= spi_miso;
      miso_q2    <= miso_q1;
    end
  end

  assign wr_ready = load_data & ~rw_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign spi_csn  = csn_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = sh_q[7];
endmodule

// File: tb/tb_spi_ram_master.sv
// tb_spi_ram_master: table vectors, hand sequences and random traffic
// against a RAM slave model and frame expectations from protocol rules.
`timescale 1ns/1ps
module tb_spi_ram_master;
  localparam int D     = 3;
  localparam int DUMMY = 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = '0;
  logic [15:0] len = '0;
  logic [7:0]  wr_data;
  logic        wr_ready, rd_valid, busy, done;
  logic        spi_csn, spi_sck, spi_mosi, spi_miso;
  logic [7:0]  rd_data;

  always #5 clk = ~clk;

  spi_ram_master #(
    .c_clk_div(D), .c_addr_bits(32),
    .c_read_dummy(DUMMY), .c_len_bits(16)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .rw(rw),
    .addr(addr), .len(len), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .spi_csn(spi_csn), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // RAM slave: mode 0, samples MOSI on SCK rise, drives MISO on SCK fall.
  logic [7:0]  mem [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  wire_q [$];
  int          rise_n;
  int          s_bi;
  logic [7:0]  s_sr, s_cmd;
  logic [31:0] s_addr;
  logic        csn_p = 1'b1;
  logic        sck_p = 1'b0;

  function automatic logic sbit(input int k);
    int bi;
    bi = k / 8;
    if (s_cmd == 8'h01 && bi >= 5 + DUMMY)
      return mem[8'(int'(s_addr[7:0]) + bi - 5 - DUMMY)][7 - k % 8];
    return 1'b0;
  endfunction

  always @(spi_csn or spi_sck) begin
    if (spi_csn) begin
      spi_miso = 1'b0;
    end else if (csn_p) begin
      rise_n   = 0;
      spi_miso = sbit(0);
    end else if (spi_sck && !sck_p) begin
      s_sr = {s_sr[6:0], spi_mosi};
      rise_n++;
      if (rise_n % 8 == 0) begin
        s_bi = rise_n / 8 - 1;
        wire_q.push_back(s_sr);
        if (s_bi == 0) s_cmd = s_sr;
        else if (s_bi <= 4) s_addr = {s_addr[23:0], s_sr};
        else if (s_cmd == 8'h00) mem[8'(int'(s_addr[7:0]) + s_bi - 5)] = s_sr;
      end
    end else if (!spi_sck && sck_p) begin
      spi_miso = sbit(rise_n);
    end
    csn_p = spi_csn;
    sck_p = spi_sck;
  end

  // Cycle monitor, sampled mid-cycle.
  int cyc = 0, csn_lo = 0, wr_tot = 0, wr_seen = 0;
  int done_tot = 0, done_cyc = 0, hi_run = 0, last_gap = 0;
  logic [7:0] rd_q [$];

  always @(negedge clk) begin
    cyc++;
    wr_seen = wr_tot;
    if (wr_ready) wr_tot++;
    if (done) begin
      done_tot++;
      done_cyc = cyc;
    end
    if (rd_valid) rd_q.push_back(rd_data);
    if (!spi_csn) begin
      csn_lo++;
      if (hi_run != 0) last_gap = hi_run;
      hi_run = 0;
    end else begin
      hi_run++;
    end
  end

  logic [7:0] wr_buf [8];
  int         wr_base = 0;
  assign wr_data = wr_buf[3'(wr_seen - wr_base)];

  bit          cur_rw;
  logic [31:0] cur_a;
  int          cur_len;
  logic [7:0]  cur_d [8];
  int          c0, lo0, wb0, rd0, w0, dn0;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Called just after a falling clk edge; that cycle is cycle 0.
  task automatic launch();
    for (int i = 0; i < 8; i++) wr_buf[i] = cur_d[i];
    wr_base = wr_tot;
    wb0 = wr_tot;
    lo0 = csn_lo;
    rd0 = rd_q.size();
    w0  = wire_q.size();
    dn0 = done_tot;
    c0  = cyc;
    rw    = cur_rw;
    addr  = cur_a;
    len   = 16'(cur_len);
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    chk("busy_c1", busy, 1);
    chk("csn_c1", spi_csn, 0);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (done_tot == dn0 && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_seen", done_tot - dn0, 1);
  endtask

  task automatic check_frame(input int exp_csn);
    int n, bad;
    logic [7:0] exp_w [$];
    n = 5 + (cur_rw ? DUMMY : 0) + cur_len;
    chk("latency", done_cyc - c0, 16 * n * D + 3 * D);
    chk("csn_low", csn_lo - lo0, exp_csn);
    chk("wr_ready_n", wr_tot - wb0, cur_rw ? 0 : cur_len);
    chk("rd_valid_n", rd_q.size() - rd0, cur_rw ? cur_len : 0);
    exp_w.push_back(cur_rw ? 8'h01 : 8'h00);
    for (int i = 3; i >= 0; i--) exp_w.push_back(cur_a[8*i +: 8]);
    if (cur_rw) for (int i = 0; i < DUMMY; i++) exp_w.push_back(8'h00);
    for (int i = 0; i < cur_len; i++)
      exp_w.push_back(cur_rw ? 8'h00 : cur_d[i]);
    chk("wire_n", wire_q.size() - w0, n);
    bad = 0;
    for (int i = 0; i < n; i++)
      if (w0 + i >= wire_q.size() || wire_q[w0 + i] !== exp_w[i]) bad++;
    chk("wire_bytes", bad, 0);
    if (cur_rw) begin
      bad = 0;
      for (int i = 0; i < cur_len; i++)
        if (rd0 + i >= rd_q.size() || rd_q[rd0 + i] !== cur_d[i]) bad++;
      chk("rd_bytes", bad, 0);
    end else begin
      for (int i = 0; i < cur_len; i++)
        ref_mem[8'(int'(cur_a[7:0]) + i)] = cur_d[i];
    end
  endtask

  task automatic frame(input int exp_csn);
    launch();
    wait_done(16 * (cur_len + 8) * D + 50);
    check_frame(exp_csn);
  endtask

  function automatic int csn_of(input bit r, input int l);
    return (2 + 16 * (5 + (r ? DUMMY : 0) + l)) * D;
  endfunction

  typedef struct {
    bit          rw;
    logic [31:0] a;
    int          len;
    logic [31:0] d;
    int          exp_csn;
  } vec_t;
  vec_t tab [5];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lo1, dn1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33;
    ref_mem[8'h10] = 8'h11; ref_mem[8'h11] = 8'h22; ref_mem[8'h12] = 8'h33;
    for (int i = 0; i < 8; i++) wr_buf[i] = 8'h00;

    tab[0] = '{1'b0, 32'h0000_0003, 2, 32'hA55A_0000, 342};
    tab[1] = '{1'b1, 32'h0000_0010, 3, 32'h1122_3300, 438};
    tab[2] = '{1'b0, 32'h0000_0040, 0, 32'h0000_0000, 246};
    tab[3] = '{1'b0, 32'h0000_0000, 4, 32'hDEAD_BEEF, 438};
    tab[4] = '{1'b1, 32'h0000_0000, 4, 32'hDEAD_BEEF, 486};

    idle(3);
    chk("rst_pins", {spi_csn, spi_sck, spi_mosi}, 3'b100);
    chk("rst_ctl", {busy, done, wr_ready, rd_valid, rd_data}, 12'h000);
    resetn = 1'b1;
    idle(3);

    foreach (tab[k]) begin
      cur_rw  = tab[k].rw;
      cur_a   = tab[k].a;
      cur_len = tab[k].len;
      for (int i = 0; i < 8; i++)
        cur_d[i] = (i < 4) ? tab[k].d[31 - 8*i -: 8] : 8'h00;
      frame(tab[k].exp_csn);
      idle(4);
    end

    // start while busy is ignored
    cur_rw = 1'b0; cur_a = 32'h0000_0080; cur_len = 1; cur_d[0] = 8'h77;
    launch();
    idle(40);
    rw = 1'b1; addr = 32'h5555_5555; start = 1'b1;
    idle(1);
    start = 1'b0;
    wait_done(600);
    check_frame(csn_of(1'b0, 1));
    lo1 = csn_lo; dn1 = done_tot;
    idle(8 * D);
    chk("no_2nd_frame", csn_lo - lo1, 0);
    chk("no_2nd_done", done_tot - dn1, 0);

    // start in the done cycle
    cur_rw = 1'b0; cur_a = 32'h0000_0090; cur_len = 2;
    cur_d[0] = 8'h3C; cur_d[1] = 8'hC3;
    frame(csn_of(1'b0, 2));
    cur_rw = 1'b1;
    for (int i = 0; i < 2; i++) cur_d[i] = ref_mem[8'h90 + 8'(i)];
    launch();
    chk("b2b_gap", last_gap, D);
    wait_done(800);
    check_frame(csn_of(1'b1, 2));
    idle(4);

    // reset during the address bytes
    cur_rw = 1'b0; cur_a = 32'h0000_00A0; cur_len = 2;
    cur_d[0] = 8'h12; cur_d[1] = 8'h34;
    launch();
    idle(32 * D);
    resetn = 1'b0;
    #1;
    chk("rst_mid_pins", {spi_csn, spi_sck}, 2'b10);
    chk("rst_mid_busy", busy, 0);
    idle(10);
    chk("rst_mid_nodone", done_tot - dn0, 0);
    resetn = 1'b1;
    idle(3);
    frame(csn_of(1'b0, 2));
    idle(3);

    // random write / read-back against the reference memory
    for (int it = 0; it < 8; it++) begin
      cur_rw  = 1'b0;
      cur_a   = $urandom;
      cur_len = $urandom_range(0, 6);
      for (int i = 0; i < 8; i++) cur_d[i] = 8'($urandom);
      frame(csn_of(1'b0, cur_len));
      idle($urandom_range(1, 5));
      cur_rw  = 1'b1;
      cur_len = $urandom_range(1, 7);
      for (int i = 0; i < 8; i++)
        cur_d[i] = ref_mem[8'(int'(cur_a[7:0]) + i)];
      frame(csn_of(1'b1, cur_len));
      idle($urandom_range(1, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
